// File: rtl/reg_bank_pkg.sv
// Shared constants and state encoding for the register-bank arbiter.
package reg_bank_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int NREGS  = 2 ** ADDR_W;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    // Requester identifiers used for grant and owner encoding
    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection with a 1-bit priority pointer.
module rr_arb2
    import reg_bank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_reqA,
    input  logic i_reqB,
    input  logic i_upd,
    input  logic i_owner,
    output logic o_grant
);

    logic r_prio;

    // Pointer moves to the side that was not just served
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= SIDE_A;
        end else if (i_upd) begin
            r_prio <= ~i_owner;
        end
    end

    // A lone requester wins outright; a tie goes to the pointer
    always_comb begin
        o_grant = SIDE_A;
        if (i_reqA && i_reqB) begin
            o_grant = r_prio;
        end else if (i_reqB) begin
            o_grant = SIDE_B;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Arbitrates two requesters onto one register bank and runs zeroing sweeps.
module reg_bank_arbiter #(
    parameter int ADDR_W = reg_bank_pkg::ADDR_W,
    parameter int DATA_W = reg_bank_pkg::DATA_W,
    parameter int NREGS  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqA,
    input  logic              weA,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [DATA_W-1:0] wdatA,
    output logic              doneA,
    output logic [DATA_W-1:0] rdatA,
    input  logic              reqB,
    input  logic              weB,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] wdatB,
    output logic              doneB,
    output logic [DATA_W-1:0] rdatB,
    input  logic              clrStart,
    output logic              busy,
    output logic [ADDR_W-1:0] bankAddrR,
    input  logic [DATA_W-1:0] bankDatR,
    output logic [ADDR_W-1:0] bankAddrW,
    output logic [DATA_W-1:0] bankDatW,
    output logic              bankRegWrite
);

    import reg_bank_pkg::*;

    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(NREGS - 1);

    state_t            r_state;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdat;
    logic              r_clr_pend;
    logic [ADDR_W:0]   r_cnt;
    logic              r_doneA;
    logic              r_doneB;
    logic [DATA_W-1:0] r_rdatA;
    logic [DATA_W-1:0] r_rdatB;
    logic              w_grant;
    logic              w_upd;

    assign w_upd = (r_state == ST_RESP);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_reqA  (reqA),
        .i_reqB  (reqB),
        .i_upd   (w_upd),
        .i_owner (r_owner),
        .o_grant (w_grant)
    );

    // Main FSM: clear has priority in IDLE, transactions take ACCESS then RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= SIDE_A;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdat     <= '0;
            r_clr_pend <= 1'b0;
            r_cnt      <= '0;
            r_doneA    <= 1'b0;
            r_doneB    <= 1'b0;
            r_rdatA    <= '0;
            r_rdatB    <= '0;
        end else begin
            r_doneA <= 1'b0;
            r_doneB <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clrStart || r_clr_pend) begin
                        r_state    <= ST_CLEAR;
                        r_cnt      <= '0;
                        r_clr_pend <= 1'b0;
                    end else if (reqA || reqB) begin
                        r_state <= ST_ACCESS;
                        r_owner <= w_grant;
                        r_we    <= (w_grant == SIDE_B) ? weB   : weA;
                        r_addr  <= (w_grant == SIDE_B) ? addrB : addrA;
                        r_wdat  <= (w_grant == SIDE_B) ? wdatB : wdatA;
                    end
                end
                ST_ACCESS: begin
                    if (clrStart) begin
                        r_clr_pend <= 1'b1;
                    end
                    // Read data is captured only for reads; writes keep the old value
                    if (!r_we) begin
                        if (r_owner == SIDE_B) begin
                            r_rdatB <= bankDatR;
                        end else begin
                            r_rdatA <= bankDatR;
                        end
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (clrStart) begin
                        r_clr_pend <= 1'b1;
                    end
                    if (r_owner == SIDE_B) begin
                        r_doneB <= 1'b1;
                    end else begin
                        r_doneA <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bank port is driven only in ACCESS and CLEAR, otherwise held at zero
    always_comb begin
        bankAddrR    = '0;
        bankAddrW    = '0;
        bankDatW     = '0;
        bankRegWrite = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                bankAddrR    = r_addr;
                bankAddrW    = r_addr;
                bankDatW     = r_wdat;
                bankRegWrite = r_we;
            end
            ST_CLEAR: begin
                bankAddrR    = r_cnt[ADDR_W-1:0];
                bankAddrW    = r_cnt[ADDR_W-1:0];
                bankRegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy  = (r_state != ST_IDLE);
    assign doneA = r_doneA;
    assign doneB = r_doneB;
    assign rdatA = r_rdatA;
    assign rdatB = r_rdatB;

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 4, register-bank address width; DATA_W, default 4, register-bank data width; NREGS, default 2**ADDR_W, number of registers cleared by a sweep.
REQ-002 Ports SHALL be as follows; the block has one clock, and its reset is synchronous and active-high:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- reqA  in  1  requester A transaction request; held high until doneA.
- weA  in  1  A operation: 1 = write, 0 = read; held stable with reqA.
- addrA  in  ADDR_W  A register address; held stable with reqA.
- wdatA  in  DATA_W  A write data; held stable with reqA.
- doneA  out  1  one-cycle completion pulse for A.
- rdatA  out  DATA_W  A read data; valid when doneA is high and held until A's next done.
- reqB, weB, addrB, wdatB, doneB, rdatB  (same directions and widths as A)  requester B equivalents.
- clrStart  in  1  single-cycle pulse that starts a clear sweep.
- busy  out  1  high while a sweep or a transaction is in progress.
- bankAddrR  out  ADDR_W  bank read address.
- bankDatR  in  DATA_W  bank read data, combinational from bankAddrR.
- bankAddrW  out  ADDR_W  bank write address.
- bankDatW  out  DATA_W  bank write data.
- bankRegWrite  out  1  bank write enable, sampled by the bank on the clk rising edge.

Function
REQ-003 The FSM SHALL have four states: IDLE, ACCESS, RESP and CLEAR.
REQ-004 Entry from IDLE SHALL follow this priority:
- a clrStart seen in IDLE goes to CLEAR;
- otherwise any request goes to ACCESS;
- otherwise the FSM stays in IDLE.
REQ-005 Arbitration SHALL be round-robin between two requesters using a 1-bit pointer prio:
- with both requesting, the side named by prio wins;
- with one requesting, that side wins regardless of prio.
REQ-006 On entry to ACCESS, the winner's we, addr and wdat SHALL be captured into an owner register.
REQ-007 In ACCESS, the block SHALL drive the bank:
- bankAddrR = bankAddrW = captured addr;
- bankDatW = captured wdat;
- bankRegWrite = captured we.
ACCESS lasts exactly one cycle.
REQ-008 At the end of ACCESS, bankDatR SHALL be registered into the owner's rdat, for reads only; rdat is left unchanged on writes.
REQ-009 In RESP, done SHALL be pulsed for the owner only, prio SHALL be set to the non-owner, and the FSM SHALL return to IDLE.
REQ-010 Latency SHALL be two cycles: with req sampled high in IDLE at edge t, ACCESS is the cycle after t, and done is high in the cycle after edge t+2.
REQ-011 A requester that keeps req high in the cycle of its own done SHALL be treated as a new request, which is arbitrated again one cycle later in IDLE.
REQ-012 A CLEAR sweep SHALL write zero to addresses 0..NREGS-1 in ascending order, one per cycle, using an ADDR_W+1-bit counter, then return to IDLE; it lasts NREGS cycles.
REQ-013 Requests arriving during CLEAR SHALL be held pending, with no done pulse, and served after the sweep completes.
REQ-014 A clrStart arriving during ACCESS or RESP SHALL be latched and the sweep started on the next IDLE, before any request; a clrStart during CLEAR SHALL be ignored.
REQ-015 Outside ACCESS and CLEAR, bankRegWrite SHALL be 0, bank addresses 0, and bankDatW 0.
REQ-016 busy SHALL be high exactly when the state is not IDLE.
REQ-017 doneA and doneB SHALL never be high in the same cycle.

Reset
REQ-018 While rst is high at a clk edge, the block SHALL set:
- state = IDLE, prio = A;
- pending-clear latch = 0, sweep counter = 0;
- doneA = doneB = 0, rdatA = rdatB = 0;
- bankRegWrite = 0, busy = 0.
REQ-019 A reset asserted mid-transaction or mid-sweep SHALL abort it, with no done issued and no further bank writes from the next cycle on.

Structure
REQ-020 A shared package reg_bank_pkg SHALL hold ADDR_W, DATA_W, NREGS and the state encoding constants; no other module defines these.
REQ-021 One sub-module rr_arb2 SHALL hold the priority pointer and perform two-way grant selection; everything else is flat in reg_bank_arbiter.

Verification
REQ-022 Single write, then read: A writes 9 to address 5, then A reads address 5 -> bankRegWrite is high for exactly 1 cycle, doneA follows 2 cycles after each req, and the read returns rdatA = 9.
REQ-023 Contention: reqA and reqB are raised together after reset (prio = A) -> A is served first, B second, and doneA precedes doneB by exactly 3 cycles.
REQ-024 Fairness: reqA and reqB are both held high continuously for 8 transactions -> grants alternate strictly A, B, A, B, and done pulses never overlap.
REQ-025 Clear sweep: all 16 registers are preloaded with 0xF, then clrStart is pulsed with reqB held high -> exactly 16 consecutive writes of 0 to addresses 0..15, busy high for 16 cycles, then B is served and a B read of address 7 returns 0.
REQ-026 Reset mid-operation: rst is asserted in the ACCESS cycle of an A write, and again in cycle 6 of a sweep -> no doneA pulse, no bank write after the rst cycle, and all outputs match REQ-018.
